apb_master: RTL and testbench



---
 rtl/apb_master_if.sv | 32 +++
 rtl/apb_master.sv | 92 +++++++++
 tb/tb_apb_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command, response and APB bus signals of the APB initiator
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-command APB initiator; APB_MASTER_TIMEOUT_EN adds an ACCESS wait-state timeout
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          pclk,
    input  logic          preset,
    apb_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign bus.cmd_ready = (state == IDLE);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state         <= IDLE;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.pwrite <= bus.cmd_write;
                        bus.paddr  <= bus.cmd_addr;
                        bus.pwdata <= bus.cmd_wdata;
                        bus.psel   <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                ACCESS: begin
                    // pready is checked first so a completion on the limit cycle is never turned into a timeout
                    if (bus.pready) begin
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bus.pslverr;
                        bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
                        state         <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    bus.psel    <= 1'b0;
                    bus.penable <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    localparam int TO     = 4;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                waits;
        logic [DATA_W-1:0] prdata;
        logic              slverr;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest outstanding command
    always @(negedge pclk) begin
        if (!preset && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_rsp: rsp_valid with no outstanding command (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_err", bus.rsp_err, mon_e.err);
                chk("rsp_latency", cyc, mon_e.due);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(negedge pclk);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.pready    = 1'b0;
        bus.prdata    = ~v.prdata;
        bus.pslverr   = ~v.slverr;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        bus.cmd_write = ~v.write;
        chk("setup_psel", bus.psel, 1);
        chk("setup_penable", bus.penable, 0);
        chk("setup_cmd_ready", bus.cmd_ready, 0);
        chk("setup_paddr", bus.paddr, v.addr);
        chk("setup_pwrite", bus.pwrite, v.write);
        chk("setup_pwdata", bus.pwdata, v.wdata);
        sb.push_back('{v.exp_rdata, v.exp_err, cyc + 2 + v.waits});
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge pclk);
            chk("access_psel", bus.psel, 1);
            chk("access_penable", bus.penable, 1);
            chk("access_paddr", bus.paddr, v.addr);
            chk("access_pwdata", bus.pwdata, v.wdata);
            chk("access_cmd_ready", bus.cmd_ready, 0);
            if (w == v.waits) begin
                bus.pready  = 1'b1;
                bus.prdata  = v.prdata;
                bus.pslverr = v.slverr;
            end
        end
        @(negedge pclk);
        bus.pready  = 1'b0;
        bus.prdata  = ~v.prdata;
        bus.pslverr = 1'b1;
        chk("rsp_pulse", bus.rsp_valid, 1);
        chk("done_psel", bus.psel, 0);
        chk("done_penable", bus.penable, 0);
        chk("done_cmd_ready", bus.cmd_ready, 1);
        chk("done_paddr_hold", bus.paddr, v.addr);
        @(negedge pclk);
        chk("rsp_single_pulse", bus.rsp_valid, 0);
        chk("rsp_rdata_hold", bus.rsp_rdata, v.exp_rdata);
        chk("rsp_err_hold", bus.rsp_err, v.exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int setups;
        int first;
        int second;
        int n;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        vecs[0] = '{1'b1, 32'h0000_0005, 8'hA5, 0, 8'hC3, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0005, 8'h00, 2, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0014, 8'h11, 0, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 8'h00, 1, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{1'b1, 32'h8000_0000, 8'h00, 3, 8'h5A, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0000, 8'hFF, 0, 8'h81, 1'b0, 8'h81, 1'b0};

        repeat (2) @(negedge pclk);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        preset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back: cmd_valid held high across two commands
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h1;
        bus.cmd_wdata = 8'h42;
        bus.pready    = 1'b1;
        bus.prdata    = 8'h99;
        bus.pslverr   = 1'b0;
        setups = 0;
        first  = -1;
        second = -1;
        for (int i = 0; i < 20 && setups < 2; i++) begin
            @(negedge pclk);
            if (bus.psel && !bus.penable) begin
                setups++;
                chk("b2b_setup_cmd_ready", bus.cmd_ready, 0);
                if (setups == 1) begin
                    first = cyc;
                    chk("b2b_first_pwrite", bus.pwrite, 1);
                    chk("b2b_first_pwdata", bus.pwdata, 8'h42);
                    sb.push_back('{8'h00, 1'b0, cyc + 2});
                    bus.cmd_write = 1'b0;
                end else begin
                    second = cyc;
                    chk("b2b_second_pwrite", bus.pwrite, 0);
                    chk("b2b_second_paddr", bus.paddr, 32'h1);
                    sb.push_back('{8'h99, 1'b0, cyc + 2});
                    bus.cmd_valid = 1'b0;
                end
            end else if (bus.psel) begin
                chk("b2b_access_cmd_ready", bus.cmd_ready, 0);
            end
        end
        chk("b2b_setups", setups, 2);
        chk("b2b_spacing", second - first, 3);
        repeat (4) @(negedge pclk);
        bus.pready = 1'b0;
        chk("b2b_drained", sb.size(), 0);
        chk("b2b_idle_psel", bus.psel, 0);

        // Reset while in ACCESS: in-flight read is discarded
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h30;
        bus.prdata    = 8'h66;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        chk("rstmid_penable_before", bus.penable, 1);
        #2 preset = 1'b1;
        #1;
        chk("rstmid_psel", bus.psel, 0);
        chk("rstmid_penable", bus.penable, 0);
        chk("rstmid_rsp_valid", bus.rsp_valid, 0);
        chk("rstmid_cmd_ready", bus.cmd_ready, 1);
        @(negedge pclk);
        preset     = 1'b0;
        bus.pready = 1'b1;
        chk("rstmid_release_cmd_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("rstmid_no_rsp", bus.rsp_valid, 0);
        end
        bus.pready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h40;
        bus.prdata    = 8'hEE;
        bus.pslverr   = 1'b0;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        sb.push_back('{8'h00, 1'b1, cyc + 1 + TO});
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (!bus.psel) break;
            n++;
        end
        chk("to_access_cycles", n, TO);
        chk("to_cmd_ready", bus.cmd_ready, 1);
`else
        n = 0;
        run_vec('{1'b0, 32'h40, 8'h00, 100, 8'h77, 1'b0, 8'h77, 1'b0});
        chk("no_to_done", n, 0);
`endif

        repeat (3) @(negedge pclk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
